conv_window_ctrl: RTL and testbench
===================================

Name: conv_window_ctrl

Overview:
- Sequencer for the 5x5 line-buffer convolution path.
- Accepts one frame of raster-order pixels over a valid/ready handshake and generates the line-buffer write strobe and column address.
- Tags every pixel that completes a valid (unpadded) KX x KY window and forwards the tag, with output coordinates, to the MAC stage under downstream backpressure.
- Sits between the pixel source (upstream) and the line buffer / convolution engine (downstream); also reports frame-done and busy status to the top-level control.

Parameters:
IX, 28, frame width in pixels
IY, 28, frame height in pixels
KX, 5, kernel width
KY, 5, kernel height

Derived constants (localparams, not overridable):
- XW = $clog2(IX); YW = $clog2(IY)
- OX = IX-KX+1; OY = IY-KY+1
- OXW = $clog2(OX); OYW = $clog2(OY)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_start  input  1  pulse; arms controller for one frame
i_abort  input  1  synchronous abort; returns to IDLE
i_in_valid  input  1  upstream pixel valid
o_in_ready  output  1  controller accepts pixel this cycle
o_lb_wr_en  output  1  line-buffer write/shift strobe (combinational: i_in_valid & o_in_ready)
o_lb_wr_col  output  XW  column address for the write (current x count)
o_win_valid  output  1  window tag valid to MAC stage
i_win_ready  input  1  MAC stage accepts window tag
o_win_x  output  OXW  output-map column of tagged window
o_win_y  output  OYW  output-map row of tagged window
o_busy  output  1  high in STREAM or FLUSH
o_frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset: reset_n is asynchronous and active-low; the clock is clk. On reset:
  - state = IDLE
  - all counters = 0
  - o_win_valid = 0, o_win_x = 0, o_win_y = 0
  - o_busy = 0, o_frame_done = 0, o_in_ready = 0
- States: IDLE, STREAM, FLUSH, DONE.
  - IDLE -> STREAM on i_start. i_start in any other state is ignored.
  - STREAM: o_in_ready = !o_win_valid | i_win_ready (one-deep output register; no bubble when the consumer is ready).
  - Accept = i_in_valid & o_in_ready.
    - On accept, x increments.
    - At x == IX-1: x wraps to 0 and y increments.
    - Accept of pixel (IX-1, IY-1) -> FLUSH.
  - FLUSH: o_in_ready = 0. Stays in FLUSH while o_win_valid & !i_win_ready. When the output register is empty or being consumed -> DONE.
  - DONE: o_frame_done = 1 for exactly one cycle, then -> IDLE. The counters are 0 at this point.
- Window tagging:
  - An accepted pixel at (x, y) with x >= KX-1 and y >= KY-1 loads the output register on the same edge.
    - o_win_valid = 1
    - o_win_x = x-(KX-1)
    - o_win_y = y-(KY-1)
  - Latency: exactly 1 cycle from accept to o_win_valid.
  - Other pixels do not load the output register.
  - The output register clears on i_win_ready when no new tag loads on the same edge. Simultaneous consume and load keeps o_win_valid = 1 with the new coordinates.
  - o_win_x and o_win_y hold stable while o_win_valid & !i_win_ready.
  - Per frame: exactly OX*OY tags (576 at default), in raster order.
- o_lb_wr_col equals the x count at all times. It is meaningful only when o_lb_wr_en = 1.
- i_abort (any state, highest priority after reset):
  - next state IDLE; x = y = 0
  - o_win_valid cleared
  - no o_frame_done pulse
- Upstream pixels offered while not in STREAM are never accepted.
- Counter widths: x/y compare against IX-1/IY-1 exactly; no reliance on natural overflow.

Decomposition:
- Shared package conv_pkg:
  - IX, IY, KX, KY defaults
  - derived widths XW, YW, OXW, OYW
  - state encoding (2-bit enum: IDLE=0, STREAM=1, FLUSH=2, DONE=3)
- One natural sub-module: raster_xy_cnt. It is the enable-driven x/y counter with wrap and a last-pixel flag, and will be reused by the line buffer rework.
- The FSM and the output register stay in conv_window_ctrl.

Test Plan:
- Reset with i_in_valid = 1 held -> all outputs 0, o_in_ready = 0; after i_start pulse, o_in_ready = 1 next cycle.
- Full 28x28 frame, i_in_valid and i_win_ready always 1:
  - first tag (0,0) one cycle after pixel (4,4)
  - last tag (23,23) one cycle after pixel (27,27)
  - 576 tags total
  - o_frame_done pulses once, 2 cycles after the last accept
- Random i_win_ready (50%) and random i_in_valid gaps, full frame -> tag sequence identical to the previous test; coordinates never change while stalled; no pixel accepted while the register is full and not ready.
- i_win_ready = 0 when the last pixel is accepted -> controller holds in FLUSH; o_frame_done only after the ready-cycle consumes tag (23,23).
- i_abort asserted after pixel (10,12) -> IDLE next cycle, o_win_valid = 0, no o_frame_done. The next i_start frame restarts at x = y = 0 with the first tag (0,0).
- i_start pulsed mid-frame at pixel (3,8) -> ignored; frame completes normally with 576 tags.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution window sequencer.
package conv_pkg;

  localparam int IX_DEF  = 28;
  localparam int IY_DEF  = 28;
  localparam int KX_DEF  = 5;
  localparam int KY_DEF  = 5;

  localparam int XW_DEF  = $clog2(IX_DEF);
  localparam int YW_DEF  = $clog2(IY_DEF);
  localparam int OXW_DEF = $clog2(IX_DEF - KX_DEF + 1);
  localparam int OYW_DEF = $clog2(IY_DEF - KY_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/raster_xy_cnt.sv
// Enable-driven raster x/y counter with wrap at W-1/H-1 and a last-pixel flag.
module raster_xy_cnt
  import conv_pkg::*;
#(
  parameter  int W     = IX_DEF,
  parameter  int H     = IY_DEF,
  localparam int XBITS = $clog2(W),
  localparam int YBITS = $clog2(H)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic             last
);

  localparam logic [XBITS-1:0] X_MAX = XBITS'(W - 1);
  localparam logic [YBITS-1:0] Y_MAX = YBITS'(H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // Advance one pixel per enable; the last pixel wraps both counters to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YBITS'(1);
      end else begin
        x <= x + XBITS'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the line-buffer convolution path: accepts one raster frame,
// strobes the line buffer and tags every pixel that closes a full KX x KY window.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter  int IX  = IX_DEF,
  parameter  int IY  = IY_DEF,
  parameter  int KX  = KX_DEF,
  parameter  int KY  = KY_DEF,
  localparam int XW  = $clog2(IX),
  localparam int YW  = $clog2(IY),
  localparam int OX  = IX - KX + 1,
  localparam int OY  = IY - KY + 1,
  localparam int OXW = $clog2(OX),
  localparam int OYW = $clog2(OY)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  output logic           o_lb_wr_en,
  output logic [XW-1:0]  o_lb_wr_col,
  output logic           o_win_valid,
  input  logic           i_win_ready,
  output logic [OXW-1:0] o_win_x,
  output logic [OYW-1:0] o_win_y,
  output logic           o_busy,
  output logic           o_frame_done
);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last_px;
  logic          accept;
  logic          win_hit;

  // The tag register is one deep, so a pixel may enter whenever the slot is
  // empty or is being drained on this same edge.
  assign o_in_ready  = (state == STREAM) && (!o_win_valid || i_win_ready);
  assign accept      = i_in_valid && o_in_ready;
  assign o_lb_wr_en  = accept;
  assign o_lb_wr_col = x;
  assign win_hit     = accept && (x >= XW'(KX - 1)) && (y >= YW'(KY - 1));

  raster_xy_cnt #(
    .W(IX),
    .H(IY)
  ) u_xy (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (i_abort),
    .en      (accept),
    .x       (x),
    .y       (y),
    .last    (last_px)
  );

  // Frame sequencing, status flags and the one-deep window tag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_win_valid  <= 1'b0;
      o_win_x      <= '0;
      o_win_y      <= '0;
    end else if (i_abort) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_win_valid  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;

      if (win_hit) begin
        o_win_valid <= 1'b1;
        o_win_x     <= OXW'(x - XW'(KX - 1));
        o_win_y     <= OYW'(y - YW'(KY - 1));
      end else if (i_win_ready) begin
        o_win_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= STREAM;
            o_busy <= 1'b1;
          end
        end
        STREAM: begin
          if (accept && last_px) state <= FLUSH;
        end
        FLUSH: begin
          if (!o_win_valid || i_win_ready) begin
            state        <= DONE;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: randomized handshakes against a
// frame-level reference model (pixel index arithmetic and raster tag list).
module tb_conv_window_ctrl;

  localparam int IX   = 28;
  localparam int IY   = 28;
  localparam int KX   = 5;
  localparam int KY   = 5;
  localparam int OX   = IX - KX + 1;
  localparam int OY   = IY - KY + 1;
  localparam int NPIX = IX * IY;
  localparam int NTAG = OX * OY;
  localparam int XW   = $clog2(IX);
  localparam int OXW  = $clog2(OX);
  localparam int OYW  = $clog2(OY);
  localparam int MAX_CYC = 20000;

  localparam int P_IDLE   = 0;
  localparam int P_STREAM = 1;
  localparam int P_FLUSH  = 2;
  localparam int P_DONE   = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_abort = 1'b0;
  logic           i_in_valid = 1'b0;
  logic           i_win_ready = 1'b0;
  logic           o_in_ready;
  logic           o_lb_wr_en;
  logic [XW-1:0]  o_lb_wr_col;
  logic           o_win_valid;
  logic [OXW-1:0] o_win_x;
  logic [OYW-1:0] o_win_y;
  logic           o_busy;
  logic           o_frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_window_ctrl #(
    .IX(IX), .IY(IY), .KX(KX), .KY(KY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_lb_wr_en   (o_lb_wr_en),
    .o_lb_wr_col  (o_lb_wr_col),
    .o_win_valid  (o_win_valid),
    .i_win_ready  (i_win_ready),
    .o_win_x      (o_win_x),
    .o_win_y      (o_win_y),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  // Runs one frame from an i_start pulse until the controller is back in IDLE.
  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic run_frame(input int vpct, input int rpct, input int abort_at,
                           input int start_at, input bit stall_last,
                           output int tags, output int dones,
                           output int last_acc_cyc, output int done_cyc,
                           output int acc44_cyc, output int first_tag_cyc);
    int n = 0;
    int phase = P_STREAM;
    int cyc = 0;
    int flush_cyc = 0;
    bit m_valid = 1'b0;
    int mx = 0;
    int my = 0;
    bit acc;
    bit exp_ready;
    bit mid_start_done = 1'b0;
    int px;
    int py;
    tags = 0; dones = 0; last_acc_cyc = -1; done_cyc = -1;
    acc44_cyc = -1; first_tag_cyc = -1;

    @(negedge clk);
    i_start = 1'b1; i_in_valid = 1'b1; i_win_ready = 1'b1; i_abort = 1'b0;
    #1;
    n_cmp++;
    if (o_in_ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_ready: got %b want 0", o_in_ready);
    end
    @(negedge clk);
    i_start = 1'b0;

    forever begin
      i_in_valid  = ($urandom_range(99) < vpct);
      i_win_ready = ($urandom_range(99) < rpct);
      if (stall_last && phase == P_STREAM && n == NPIX - 1) i_win_ready = 1'b1;
      if (stall_last && phase == P_FLUSH && flush_cyc < 4) i_win_ready = 1'b0;
      i_start = 1'b0;
      if (start_at >= 0 && phase == P_STREAM && n == start_at && !mid_start_done) begin
        i_start = 1'b1; mid_start_done = 1'b1;
      end
      i_abort = (abort_at >= 0 && phase == P_STREAM && n == abort_at + 1);
      #1;

      exp_ready = (phase == P_STREAM) && (!m_valid || i_win_ready);
      acc = exp_ready && i_in_valid;

      n_cmp++;
      if (o_in_ready !== exp_ready) begin
        n_bad++; $display("FAIL in_ready cyc %0d: got %b want %b", cyc, o_in_ready, exp_ready);
      end
      n_cmp++;
      if (o_lb_wr_en !== acc) begin
        n_bad++; $display("FAIL lb_wr_en cyc %0d: got %b want %b", cyc, o_lb_wr_en, acc);
      end
      n_cmp++;
      if (o_lb_wr_col !== XW'(n % IX)) begin
        n_bad++; $display("FAIL lb_wr_col cyc %0d: got %0d want %0d", cyc, o_lb_wr_col, n % IX);
      end
      n_cmp++;
      if (o_win_valid !== m_valid) begin
        n_bad++; $display("FAIL win_valid cyc %0d: got %b want %b", cyc, o_win_valid, m_valid);
      end
      if (m_valid) begin
        n_cmp++;
        if (o_win_x !== OXW'(mx) || o_win_y !== OYW'(my)) begin
          n_bad++;
          $display("FAIL win_xy cyc %0d: got (%0d,%0d) want (%0d,%0d)", cyc, o_win_x, o_win_y, mx, my);
        end
      end
      n_cmp++;
      if (o_busy !== (phase == P_STREAM || phase == P_FLUSH)) begin
        n_bad++; $display("FAIL busy cyc %0d: got %b phase %0d", cyc, o_busy, phase);
      end
      n_cmp++;
      if (o_frame_done !== (phase == P_DONE)) begin
        n_bad++; $display("FAIL frame_done cyc %0d: got %b phase %0d", cyc, o_frame_done, phase);
      end
      if (o_frame_done === 1'b1) dones++;
      if (phase == P_DONE) done_cyc = cyc;
      if (o_win_valid === 1'b1 && first_tag_cyc < 0) first_tag_cyc = cyc;

      // Each consumed tag must be the next one of the raster-order tag list
      if (m_valid && i_win_ready && !i_abort) begin
        n_cmp++;
        if (o_win_x !== OXW'(tags % OX) || o_win_y !== OYW'(tags / OX)) begin
          n_bad++;
          $display("FAIL tag_seq #%0d: got (%0d,%0d) want (%0d,%0d)", tags, o_win_x, o_win_y,
                   tags % OX, tags / OX);
        end
        tags++;
      end

      if (phase == P_IDLE) break;

      if (phase == P_DONE) begin
        phase = P_IDLE;
      end else if (i_abort) begin
        phase = P_IDLE; m_valid = 1'b0; n = 0;
      end else begin
        if (phase == P_FLUSH) begin
          if (!(m_valid && !i_win_ready)) phase = P_DONE;
          flush_cyc++;
        end
        if (acc) begin
          px = n % IX; py = n / IX;
          if (px == KX - 1 && py == KY - 1) acc44_cyc = cyc;
          n++;
          if (n == NPIX) begin
            phase = P_FLUSH; n = 0; last_acc_cyc = cyc;
          end
          if (px >= KX - 1 && py >= KY - 1) begin
            m_valid = 1'b1; mx = px - (KX - 1); my = py - (KY - 1);
          end else if (i_win_ready) begin
            m_valid = 1'b0;
          end
        end else if (i_win_ready) begin
          m_valid = 1'b0;
        end
      end

      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc > MAX_CYC) begin
        n_cmp++; n_bad++;
        $display("FAIL frame_timeout: got %0d cycles want <= %0d", cyc, MAX_CYC);
        break;
      end
    end
    i_in_valid = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_win_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_in_valid = 1'b1; i_win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (o_in_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", o_in_ready); end
    n_cmp++; if (o_lb_wr_en !== 1'b0)   begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", o_lb_wr_en); end
    n_cmp++; if (o_lb_wr_col !== '0)    begin n_bad++; $display("FAIL rst_wr_col: got %0d want 0", o_lb_wr_col); end
    n_cmp++; if (o_win_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_win_valid: got %b want 0", o_win_valid); end
    n_cmp++; if (o_win_x !== '0 || o_win_y !== '0) begin
      n_bad++; $display("FAIL rst_win_xy: got (%0d,%0d) want (0,0)", o_win_x, o_win_y);
    end
    n_cmp++; if (o_busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", o_frame_done); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (o_in_ready !== 1'b0)   begin n_bad++; $display("FAIL idle_no_accept: got %b want 0", o_in_ready); end
    i_in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int tags, dones, la, dc, a44, ft;
    run_frame(100, 100, -1, -1, 1'b0, tags, dones, la, dc, a44, ft);
    n_cmp++; if (tags !== NTAG) begin n_bad++; $display("FAIL full_tags: got %0d want %0d", tags, NTAG); end
    n_cmp++; if (dones !== 1)   begin n_bad++; $display("FAIL full_dones: got %0d want 1", dones); end
    n_cmp++; if (dc - la !== 2) begin n_bad++; $display("FAIL full_done_lat: got %0d want 2", dc - la); end
    n_cmp++; if (a44 < 0 || ft - a44 !== 1) begin
      n_bad++; $display("FAIL first_tag_lat: got %0d want 1", ft - a44);
    end
  endtask

  task automatic test_random_stall();
    int tags, dones, la, dc, a44, ft;
    for (int f = 0; f < 2; f++) begin
      run_frame(70, 50, -1, -1, 1'b0, tags, dones, la, dc, a44, ft);
      n_cmp++; if (tags !== NTAG) begin n_bad++; $display("FAIL rand_tags: got %0d want %0d", tags, NTAG); end
      n_cmp++; if (dones !== 1)   begin n_bad++; $display("FAIL rand_dones: got %0d want 1", dones); end
    end
  endtask

  task automatic test_flush_hold();
    int tags, dones, la, dc, a44, ft;
    run_frame(100, 100, -1, -1, 1'b1, tags, dones, la, dc, a44, ft);
    n_cmp++; if (tags !== NTAG) begin n_bad++; $display("FAIL flush_tags: got %0d want %0d", tags, NTAG); end
    n_cmp++; if (dones !== 1)   begin n_bad++; $display("FAIL flush_dones: got %0d want 1", dones); end
    n_cmp++; if (dc - la !== 6) begin n_bad++; $display("FAIL flush_done_lat: got %0d want 6", dc - la); end
  endtask

  task automatic test_abort();
    int tags, dones, la, dc, a44, ft;
    run_frame(100, 100, 12 * IX + 10, -1, 1'b0, tags, dones, la, dc, a44, ft);
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_dones: got %0d want 0", dones); end
    n_cmp++; if (la !== -1)   begin n_bad++; $display("FAIL abort_completed: got %0d want -1", la); end
    run_frame(90, 90, -1, -1, 1'b0, tags, dones, la, dc, a44, ft);
    n_cmp++; if (tags !== NTAG) begin n_bad++; $display("FAIL restart_tags: got %0d want %0d", tags, NTAG); end
    n_cmp++; if (dones !== 1)   begin n_bad++; $display("FAIL restart_dones: got %0d want 1", dones); end
  endtask

  task automatic test_start_ignored();
    int tags, dones, la, dc, a44, ft;
    run_frame(80, 80, -1, 8 * IX + 3, 1'b0, tags, dones, la, dc, a44, ft);
    n_cmp++; if (tags !== NTAG) begin n_bad++; $display("FAIL midstart_tags: got %0d want %0d", tags, NTAG); end
    n_cmp++; if (dones !== 1)   begin n_bad++; $display("FAIL midstart_dones: got %0d want 1", dones); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_stall();
    test_flush_hold();
    test_abort();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
